// File: rtl/vm2_irq_pkg.sv
// ============================================================================
// Module  : vm2_irq_pkg
// Purpose : Shared types and constants for the 1801VM2 vectored interrupt
//           controller (vm2_irq_ctl and vm2_irq_prio_enc).
// Contents: state_t  - controller state encoding {ST_IDLE, ST_ARB, ST_ACK}
//           SPUR_VEC_DEF - default spurious vector (octal 374)
//           MAX_SRC  - largest supported number of request sources
//           IDX_W    - width of a source index / priority pointer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vm2_irq_pkg;

   localparam int          MAX_SRC      = 16;
   localparam int          IDX_W        = 4;
   localparam logic [15:0] SPUR_VEC_DEF = 16'o000374;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/vm2_irq_prio_enc.sv
// ============================================================================
// Module  : vm2_irq_prio_enc
// Purpose : Combinational rotating priority encoder. The search begins at
//           index 'start' and wraps modulo N_SRC; the first active request
//           found wins. With start = 0 it is a plain fixed-priority encoder
//           (index 0 highest).
// Ports   : req     in  N_SRC  request vector
//           start   in  IDX_W  index with highest priority (< N_SRC)
//           win_idx out IDX_W  winning index (0 when nothing is active)
//           win_oh  out N_SRC  one-hot winner (all 0 when nothing is active)
//           any     out 1      at least one request active
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vm2_irq_prio_enc
   import vm2_irq_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] win_idx,
   output logic [N_SRC-1:0] win_oh,
   output logic             any
);

   localparam int POS_W = IDX_W + 1;

   logic [MAX_SRC-1:0] req_ext;
   logic [POS_W-1:0]   pos;

   assign req_ext = MAX_SRC'(req);

   // Walk the offsets from farthest to nearest so that the candidate closest
   // to 'start' is the last one written and therefore wins.
   always_comb begin
      win_idx = '0;
      any     = 1'b0;
      pos     = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         pos = {1'b0, start} + POS_W'(i);
         if (pos >= POS_W'(N_SRC)) begin
            pos = pos - POS_W'(N_SRC);
         end
         if (req_ext[pos[IDX_W-1:0]]) begin
            win_idx = pos[IDX_W-1:0];
            any     = 1'b1;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_SRC; g++) begin : g_onehot
         assign win_oh[g] = any && (win_idx == IDX_W'(g));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/vm2_irq_ctl.sv
// ============================================================================
// Module  : vm2_irq_ctl
// Purpose : Vectored interrupt controller for the 1801VM2 processor module.
//           Collects level requests, drives virq, answers the CPU vector
//           fetch (istb) with ivec/iack and pulses irq_ack to the granted
//           source for one cycle so it can drop its request.
// Config  : `define VM2_IRQ_ROUND_ROBIN_EN for rotating priority (pointer
//           moves to k+1 after a grant of k). Without it, priority is fixed
//           with index 0 highest and no pointer register exists.
// Ports   : clk_p   in  1         bus clock, rising edge
//           rst_n   in  1         synchronous active-low reset
//           irq_req in  N_SRC     level requests
//           vec_tab in  16*N_SRC  vector of source i at [16i+15:16i]
//           irq_ack out N_SRC     one-cycle grant pulse
//           virq    out 1         interrupt request to the CPU
//           istb    in  1         CPU vector-fetch strobe
//           ivec    out 16        vector to the CPU
//           iack    out 1         vector-valid acknowledge
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vm2_irq_ctl
   import vm2_irq_pkg::*;
#(
   parameter int          N_SRC    = 4,
   parameter logic [15:0] SPUR_VEC = SPUR_VEC_DEF
) (
   input  logic                clk_p,
   input  logic                rst_n,
   input  logic [N_SRC-1:0]    irq_req,
   input  logic [16*N_SRC-1:0] vec_tab,
   output logic [N_SRC-1:0]    irq_ack,
   output logic                virq,
   input  logic                istb,
   output logic [15:0]         ivec,
   output logic                iack
);

   state_t             state;
   logic [IDX_W-1:0]   start;
   logic [IDX_W-1:0]   win_idx;
   logic [N_SRC-1:0]   win_oh;
   logic               any;
   logic [15:0]        sel_vec;
   logic [15:0]        arb_vec;

`ifdef VM2_IRQ_ROUND_ROBIN_EN
   logic [IDX_W-1:0]   ptr;
   assign start = ptr;
`else
   assign start = '0;
`endif

   vm2_irq_prio_enc #(
      .N_SRC   (N_SRC)
   ) u_prio_enc (
      .req     (irq_req),
      .start   (start),
      .win_idx (win_idx),
      .win_oh  (win_oh),
      .any     (any)
   );

   always_comb begin
      sel_vec = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (win_idx == IDX_W'(i)) begin
            sel_vec = vec_tab[16*i +: 16];
         end
      end
   end

   // Vectors are word-pair aligned on the VM2; the low two bits are forced
   // clear. With no active request the spurious vector is returned instead.
   assign arb_vec = any ? (sel_vec & 16'hFFFC) : SPUR_VEC;

   always_ff @(posedge clk_p) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         virq    <= 1'b0;
         iack    <= 1'b0;
         ivec    <= '0;
         irq_ack <= '0;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
         ptr     <= '0;
`endif
      end else begin
         // The grant pulse lasts exactly one cycle (first ACK cycle).
         irq_ack <= '0;
         case (state)
            ST_IDLE: begin
               iack <= 1'b0;
               ivec <= '0;
               if (istb) begin
                  state <= ST_ARB;
                  virq  <= 1'b0;
               end else begin
                  // Re-evaluated here rather than on the ACK->IDLE edge so
                  // the granted device has a cycle to drop its request.
                  virq  <= |irq_req;
               end
            end

            ST_ARB: begin
               virq <= 1'b0;
               if (istb) begin
                  state   <= ST_ACK;
                  iack    <= 1'b1;
                  ivec    <= arb_vec;
                  irq_ack <= win_oh;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
                  if (any) begin
                     ptr <= (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
                  end
`endif
               end else begin
                  // Strobe withdrawn: abandon the fetch without any handshake.
                  state <= ST_IDLE;
                  iack  <= 1'b0;
                  ivec  <= '0;
               end
            end

            ST_ACK: begin
               virq <= 1'b0;
               if (!istb) begin
                  state <= ST_IDLE;
                  iack  <= 1'b0;
                  ivec  <= '0;
               end
            end

            default: begin
               state <= ST_IDLE;
               virq  <= 1'b0;
               iack  <= 1'b0;
               ivec  <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vm2_irq_ctl.sv
// ============================================================================
// Module  : tb_vm2_irq_ctl
// Purpose : Self-checking bench for vm2_irq_ctl. A table of per-cycle input
//           vectors with expected outputs, followed by hand-written sequences
//           for mid-fetch reset and priority rotation. Honours
//           VM2_IRQ_ROUND_ROBIN_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vm2_irq_ctl;

   localparam int N = 4;

   logic            clk_p = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    irq_req = '0;
   logic [16*N-1:0] vec_tab;
   logic [N-1:0]    irq_ack;
   logic            virq;
   logic            istb = 1'b0;
   logic [15:0]     ivec;
   logic            iack;

   int checks = 0;
   int passed = 0;

   always #5 clk_p = ~clk_p;

   vm2_irq_ctl #(
      .N_SRC    (N),
      .SPUR_VEC (16'o000374)
   ) dut (
      .clk_p   (clk_p),
      .rst_n   (rst_n),
      .irq_req (irq_req),
      .vec_tab (vec_tab),
      .irq_ack (irq_ack),
      .virq    (virq),
      .istb    (istb),
      .ivec    (ivec),
      .iack    (iack)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic        stb;
      logic        e_virq;
      logic        e_iack;
      logic [15:0] e_ivec;
      logic [3:0]  e_ack;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] q, input logic s,
                      input logic ev, input logic ei, input logic [15:0] evec,
                      input logic [3:0] ea);
      vec_t v;
      v.rst = r; v.req = q; v.stb = s;
      v.e_virq = ev; v.e_iack = ei; v.e_ivec = evec; v.e_ack = ea;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
   endtask

   // Drive inputs on the falling edge, then sample 1 time unit after the
   // following rising edge.
   task automatic step(input logic r, input logic [3:0] q, input logic s);
      @(negedge clk_p);
      rst_n = r; irq_req = q; istb = s;
      @(posedge clk_p);
      #1;
   endtask

   logic [3:0] rr_exp [3];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_tab = {16'o000070, 16'o000064, 16'o000060, 16'o000063};

      // reset held 3 cycles with all requests high
      add(0, 4'b1111, 0, 0, 0, 16'o0,   4'b0000);
      add(0, 4'b1111, 0, 0, 0, 16'o0,   4'b0000);
      add(0, 4'b1111, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b1111, 0, 1, 0, 16'o0,   4'b0000);
      // fixed priority, istb high 4 cycles
      add(1, 4'b0110, 0, 1, 0, 16'o0,   4'b0000);
      add(1, 4'b0110, 1, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0110, 1, 0, 1, 16'o60,  4'b0010);
      add(1, 4'b0110, 1, 0, 1, 16'o60,  4'b0000);
      add(1, 4'b0110, 1, 0, 1, 16'o60,  4'b0000);
      add(1, 4'b0110, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0110, 0, 1, 0, 16'o0,   4'b0000);
      // spurious fetch
      add(1, 4'b0000, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0000, 1, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0000, 1, 0, 1, 16'o374, 4'b0000);
      add(1, 4'b0000, 1, 0, 1, 16'o374, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0000, 0, 0, 0, 16'o0,   4'b0000);
      // aborted fetch
      add(1, 4'b0001, 0, 1, 0, 16'o0,   4'b0000);
      add(1, 4'b0001, 1, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0001, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0001, 0, 1, 0, 16'o0,   4'b0000);
      // alignment: source0 vector 063 -> 060
      add(1, 4'b0001, 1, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0001, 1, 0, 1, 16'o60,  4'b0001);
      add(1, 4'b0000, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0000, 0, 0, 0, 16'o0,   4'b0000);
      // request arriving during ACK does not disturb the grant
      add(1, 4'b0100, 1, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0100, 1, 0, 1, 16'o64,  4'b0100);
      add(1, 4'b0101, 1, 0, 1, 16'o64,  4'b0000);
      add(1, 4'b0101, 0, 0, 0, 16'o0,   4'b0000);
      add(1, 4'b0101, 0, 1, 0, 16'o0,   4'b0000);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].stb);
         chk($sformatf("row%0d virq", i),    16'(virq),    16'(tbl[i].e_virq));
         chk($sformatf("row%0d iack", i),    16'(iack),    16'(tbl[i].e_iack));
         chk($sformatf("row%0d ivec", i),    ivec,         tbl[i].e_ivec);
         chk($sformatf("row%0d irq_ack", i), 16'(irq_ack), 16'(tbl[i].e_ack));
      end

      // reset arriving during ARB: grant is lost
      step(1, 4'b0001, 0);
      step(1, 4'b0001, 1);
      chk("midrst arb virq", 16'(virq), 16'd0);
      step(0, 4'b0001, 1);
      chk("midrst iack",    16'(iack),    16'd0);
      chk("midrst irq_ack", 16'(irq_ack), 16'd0);
      chk("midrst ivec",    ivec,         16'o0);
      step(1, 4'b0001, 0);
      chk("midrst virq after", 16'(virq),    16'd1);
      chk("midrst no late ack", 16'(irq_ack), 16'd0);
      step(1, 4'b0001, 0);
      chk("midrst iack idle", 16'(iack), 16'd0);

      // three fetches with two requests held
`ifdef VM2_IRQ_ROUND_ROBIN_EN
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0001;
`else
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0001;
`endif
      for (int k = 0; k < 3; k++) begin
         step(1, 4'b0011, 1);
         step(1, 4'b0011, 1);
         chk($sformatf("prio fetch%0d irq_ack", k), 16'(irq_ack), 16'(rr_exp[k]));
         chk($sformatf("prio fetch%0d iack", k),    16'(iack),    16'd1);
         step(1, 4'b0011, 0);
         chk($sformatf("prio fetch%0d iack fall", k), 16'(iack), 16'd0);
         step(1, 4'b0011, 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
